// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and helpers for mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;
  localparam int WORD_ALIGN_BITS = 3;
  function automatic int lat_cnt_w(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational winner selection between fetch and data requesters.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       owner
);
  // On a tie, data wins unless data was the last one granted.
  assign gnt[1] = d_req & (~if_req | (last_grant == OWN_FETCH));
  assign gnt[0] = if_req & ~gnt[1];
  assign owner  = gnt[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between fetch and load/store paths.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate ties instead of data-over-fetch priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ready,
  output logic [63:0]       d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_wr,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);
  localparam int CW = lat_cnt_w(MEM_LATENCY);
  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [63:0]       d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              mem_wr_q, mem_wr_d;
  logic [1:0]        gnt;
  logic              gnt_owner;
  logic              last_grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_t last_q, last_d;
  assign last_d = (state_q == IDLE && |gnt) ? arb_owner_t'(gnt_owner) : last_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) last_q <= OWN_DATA;
    else last_q <= last_d;
  assign last_grant = last_q;
`else
  // Pretending fetch won last makes data win every tie.
  assign last_grant = OWN_FETCH;
`endif

  mem_arb_grant u_grant (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_grant(last_grant),
    .gnt       (gnt),
    .owner     (gnt_owner)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    mem_wr_d   = 1'b0;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d  = ISSUE;
        owner_d  = arb_owner_t'(gnt_owner);
        we_d     = gnt[1] & d_we;
        addr_d   = gnt[1] ? d_addr : if_addr;
        wdata_d  = gnt[1] ? d_wdata : wdata_q;
        mem_wr_d = gnt[1] & d_we;
      end
      ISSUE: begin
        state_d   = we_q ? RESP : WAIT;
        cnt_d     = CW'(MEM_LATENCY - 1);
        d_valid_d = we_q;
      end
      WAIT: if (cnt_q == '0) begin
        state_d    = RESP;
        if_valid_d = owner_q == OWN_FETCH;
        d_valid_d  = owner_q == OWN_DATA;
        if_rdata_d = (owner_q == OWN_FETCH) ? (addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0]) : if_rdata_q;
        d_rdata_d  = (owner_q == OWN_DATA) ? mem_rdata : d_rdata_q;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_DATA;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      mem_wr_q   <= mem_wr_d;
    end

  assign if_ready  = (state_q == IDLE) & gnt[0];
  assign d_ready   = (state_q == IDLE) & gnt[1];
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign mem_addr  = addr_q & ~ADDR_W'((1 << WORD_ALIGN_BITS) - 1);
  assign mem_wdata = wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter at latencies 1 and 4.
module tb_mem_port_arbiter;
  typedef struct {
    bit          fetch;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clock = 0;
  logic reset;
  always #5 clock = ~clock;

  logic        if_req, if_ready, if_valid, d_req, d_we, d_ready, d_valid, mem_wr, busy;
  logic [63:0] if_addr, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] if_rdata;
  logic        if_req4, if_ready4, if_valid4, d_req4, d_we4, d_ready4, d_valid4, mem_wr4, busy4;
  logic [63:0] if_addr4, d_addr4, d_wdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic [31:0] if_rdata4;

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(64)) dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(4), .ADDR_W(64)) dut4 (
    .clock(clock), .reset(reset),
    .if_req(if_req4), .if_addr(if_addr4), .if_ready(if_ready4), .if_rdata(if_rdata4), .if_valid(if_valid4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4), .d_ready(d_ready4),
    .d_rdata(d_rdata4), .d_valid(d_valid4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_wr(mem_wr4), .mem_rdata(mem_rdata4), .busy(busy4)
  );

  logic [63:0] mem [256];
  logic [63:0] pipe1;
  logic [63:0] pipe4 [4];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[8'h20] = 64'hAAAA_BBBB_1111_2222;
    mem[8'h08] = 64'hDEAD_BEEF_0000_0001;
    mem[8'h40] = 64'h5555_6666_7777_8888;
  end
  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem[a[10:3]];
  endfunction
  // Memory samples the address each edge; data appears MEM_LATENCY cycles later.
  always @(posedge clock) begin
    pipe1    <= rd(mem_addr);
    pipe4[0] <= rd(mem_addr4);
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign mem_rdata  = pipe1;
  assign mem_rdata4 = pipe4[3];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  exp_t q1[$], q4[$];
  exp_t e1, e4;
  always @(negedge clock)
    if (if_valid || d_valid) begin
      if (q1.size() == 0) chk("dut1 unexpected strobe", {if_valid, d_valid}, 2'b00);
      else begin
        e1 = q1.pop_front();
        chk("dut1 strobe", {if_valid, d_valid}, e1.fetch ? 2'b10 : 2'b01);
        chk("dut1 rdata", e1.fetch ? {32'h0, if_rdata} : d_rdata, e1.data);
        chk("dut1 resp cycle", cyc, e1.cyc);
      end
    end
  always @(negedge clock)
    if (if_valid4 || d_valid4) begin
      if (q4.size() == 0) chk("dut4 unexpected strobe", {if_valid4, d_valid4}, 2'b00);
      else begin
        e4 = q4.pop_front();
        chk("dut4 strobe", {if_valid4, d_valid4}, e4.fetch ? 2'b10 : 2'b01);
        chk("dut4 rdata", e4.fetch ? {32'h0, if_rdata4} : d_rdata4, e4.data);
        chk("dut4 resp cycle", cyc, e4.cyc);
      end
    end

  function automatic logic rdy(input int s);
    return s == 0 ? if_ready : s == 1 ? d_ready : s == 2 ? if_ready4 : d_ready4;
  endfunction
  task automatic accept(input int s, input string nm, output int t);
    int k = 0;
    #1;
    while (!rdy(s) && k < 20) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk(nm, rdy(s), 1);
    t = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int t, t2, n;
  logic [63:0] exp_d1 = 64'h0;
  initial begin
    reset = 0;
    {if_req, d_req, d_we, if_req4, d_req4, d_we4} = '0;
    {if_addr, d_addr, d_wdata, if_addr4, d_addr4, d_wdata4} = '0;
    repeat (2) @(negedge clock);
    chk("reset ctrl", {busy, if_valid, d_valid, mem_wr, if_ready, d_ready, busy4, mem_wr4}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset d_rdata", d_rdata, 0);
    reset = 1;
    // Fetch alone, upper half selected by addr[2]; request dropped right after accept
    @(negedge clock);
    if_req = 1; if_addr = 64'h104;
    accept(0, "A accept", t);
    q1.push_back('{1'b1, 64'hAAAABBBB, t + 3});
    @(negedge clock);
    if_req = 0;
    chk("A mem_addr", mem_addr, 64'h100);
    chk("A mem_wr", mem_wr, 0);
    repeat (3) @(negedge clock);
    chk("A idle", busy, 0);
    @(negedge clock);
    chk("A no second txn", busy, 0);
    // Store with unaligned address; fetch pulsed while busy must be ignored
    @(negedge clock);
    d_req = 1; d_we = 1; d_addr = 64'h2F; d_wdata = 64'h0123_4567_89AB_CDEF;
    accept(1, "B accept", t);
    q1.push_back('{1'b0, exp_d1, t + 2});
    @(negedge clock);
    d_req = 0; d_we = 0;
    chk("B mem_wr", mem_wr, 1);
    chk("B mem_addr", mem_addr, 64'h28);
    chk("B mem_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
    if_req = 1; if_addr = 64'h200;
    #1 chk("B fetch blocked", if_ready, 0);
    @(negedge clock);
    if_req = 0;
    chk("B mem_wr one cycle", mem_wr, 0);
    @(negedge clock);
    chk("B idle", busy, 0);
    // Tie: data wins, fetch accepted at first IDLE after d_valid
    @(negedge clock);
    if_req = 1; if_addr = 64'h200; d_req = 1; d_addr = 64'h40;
    #1;
    chk("C d_ready", d_ready, 1);
    chk("C if_ready", if_ready, 0);
    t = cyc;
    exp_d1 = 64'hDEAD_BEEF_0000_0001;
    q1.push_back('{1'b0, exp_d1, t + 3});
    @(negedge clock);
    d_req = 0;
    accept(0, "C fetch accept", t2);
    chk("C fetch accept cycle", t2, t + 4);
    q1.push_back('{1'b1, 64'h77778888, t2 + 3});
    @(negedge clock);
    if_req = 0;
    repeat (4) @(negedge clock);
    // Latency 4 load
    @(negedge clock);
    d_req4 = 1; d_addr4 = 64'h40;
    accept(3, "D accept", t);
    q4.push_back('{1'b0, 64'hDEAD_BEEF_0000_0001, t + 6});
    n = 0;
    repeat (5) begin
      @(negedge clock);
      d_req4 = 0;
      n += int'(busy4);
    end
    chk("D busy before valid", n, 5);
    @(negedge clock);
    chk("D busy in resp", busy4, 1);
    @(negedge clock);
    chk("D idle", busy4, 0);
    // Reset during the store's write cycle
    @(negedge clock);
    d_req = 1; d_we = 1; d_addr = 64'h8; d_wdata = 64'h0F0F_0F0F_0F0F_0F0F;
    accept(1, "E1 accept", t);
    @(negedge clock);
    d_req = 0; d_we = 0;
    chk("E1 mem_wr before reset", mem_wr, 1);
    reset = 0;
    #1;
    chk("E1 async reset", {mem_wr, busy, if_valid, d_valid}, 0);
    chk("E1 mem_addr", mem_addr, 0);
    chk("E1 d_rdata cleared", d_rdata, 0);
    chk("E1 d_rdata4 cleared", d_rdata4, 0);
    exp_d1 = 64'h0;
    @(negedge clock);
    reset = 1;
    // Reset during WAIT of a latency-4 load
    @(negedge clock);
    d_req4 = 1; d_addr4 = 64'h40;
    accept(3, "E2 accept", t);
    @(negedge clock);
    d_req4 = 0;
    repeat (2) @(negedge clock);
    chk("E2 in wait", busy4, 1);
    reset = 0;
    #1 chk("E2 async reset", {busy4, mem_wr4, if_valid4, d_valid4}, 0);
    @(negedge clock);
    reset = 1;
    // Fresh fetches after reset on both instances
    @(negedge clock);
    if_req = 1; if_addr = 64'h100; if_req4 = 1; if_addr4 = 64'h104;
    accept(0, "F accept", t);
    chk("F accept4", if_ready4, 1);
    q1.push_back('{1'b1, 64'h11112222, t + 3});
    q4.push_back('{1'b1, 64'hAAAABBBB, t + 6});
    @(negedge clock);
    if_req = 0; if_req4 = 0;
    repeat (8) @(negedge clock);
    chk("F idle", {busy, busy4}, 0);
    chk("pending dut1", q1.size(), 0);
    chk("pending dut4", q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
